// File: rtl/jk_excitation_driver.sv
// Command side for a bank of gated JK flip-flops: derives J/K drive from the bank's
// current Q, issues one clock-enable strobe, waits a settle time and checks the result.
module jk_excitation_driver #(
    parameter int unsigned N      = 4,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [N-1:0]     tgt_data,
    input  logic [N-1:0]     tgt_care,
    input  logic [N-1:0]     q_in,
    output logic [N-1:0]     j_out,
    output logic [N-1:0]     k_out,
    output logic             ff_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [N-1:0]     err_bits,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_err
);

    typedef enum logic [1:0] {StIdle, StApply, StWait, StCheck} state_e;

    localparam logic [3:0] SettleLd = 4'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [N-1:0]     tgt_q, tgt_d;
    logic [N-1:0]     care_q, care_d;
    logic [N-1:0]     j_q, j_d;
    logic [N-1:0]     k_q, k_d;
    logic [N-1:0]     err_bits_q, err_bits_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [N-1:0]     mism;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        care_d     = care_q;
        j_d        = j_q;
        k_d        = k_q;
        err_bits_d = err_bits_q;
        err_cnt_d  = err_cnt_q;
        tgt_ready  = 1'b0;
        busy       = 1'b1;
        j_out      = '0;
        k_out      = '0;
        ff_en      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mism       = (q_in ^ tgt_q) & care_q;

        case (state_q)
            StIdle: begin
                tgt_ready = 1'b1;
                busy      = 1'b0;
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    care_d  = tgt_care;
                    // Excitation never requests toggle: J and K are mutually exclusive.
                    j_d     = ~q_in & tgt_data & tgt_care;
                    k_d     = q_in & ~tgt_data & tgt_care;
                    state_d = StApply;
                end
            end
            StApply: begin
                j_out   = j_q;
                k_out   = k_q;
                ff_en   = 1'b1;
                cnt_d   = SettleLd;
                state_d = StWait;
            end
            StWait: begin
                j_out = j_q;
                k_out = k_q;
                if (cnt_q == 4'd0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCheck: begin
                done       = 1'b1;
                err_bits_d = mism;
                if (|mism) begin
                    err = 1'b1;
                    if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Clear takes priority over a coincident failing check.
        if (clr_err) begin
            err_cnt_d  = '0;
            err_bits_d = '0;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tgt_q      <= '0;
            care_q     <= '0;
            j_q        <= '0;
            k_q        <= '0;
            err_bits_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            care_q     <= care_d;
            j_q        <= j_d;
            k_q        <= k_d;
            err_bits_q <= err_bits_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_bits = err_bits_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural JK bank in the loop.
module tb_jk_excitation_driver;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] tgt_data = 4'd0;
    logic [3:0] tgt_care = 4'd0;
    logic [3:0] q_in;
    logic [3:0] j_out, k_out;
    logic       ff_en, busy, done, err;
    logic [3:0] err_bits;
    logic [7:0] err_cnt;
    logic       clr_err = 1'b0;

    logic [3:0] bank_q = 4'd0;
    logic       bank_ld = 1'b0;
    logic [3:0] bank_val = 4'd0;
    logic [3:0] stuck = 4'd0;

    int checks = 0;
    int failures = 0;

    int         ff_cyc, done_cyc, ready_cyc;
    logic [3:0] obs_j, obs_k, obs_err_bits;
    logic       obs_err;
    logic [7:0] obs_err_cnt;

    always #5 clk1 = ~clk1;

    // Behavioural JK bank: updates only on the strobe; stuck bits read back as 0.
    always @(posedge clk1) begin
        if (bank_ld) bank_q <= bank_val;
        else if (ff_en) bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
    end
    assign q_in = bank_q & ~stuck;

    jk_excitation_driver #(.N(4), .SETTLE(2), .CNT_W(8)) dut (
        .clk1(clk1), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_data(tgt_data), .tgt_care(tgt_care), .q_in(q_in), .j_out(j_out),
        .k_out(k_out), .ff_en(ff_en), .busy(busy), .done(done), .err(err),
        .err_bits(err_bits), .err_cnt(err_cnt), .clr_err(clr_err)
    );

    task automatic load_bank(input logic [3:0] v);
        bank_val = v;
        bank_ld  = 1'b1;
        @(posedge clk1);
        @(negedge clk1);
        bank_ld = 1'b0;
    endtask

    // Runs one transaction from a negedge in IDLE; cycle n = value sampled at edge n.
    task automatic do_op(input logic [3:0] t, input logic [3:0] c, input bit clr_at_done);
        tgt_data  = t;
        tgt_care  = c;
        tgt_valid = 1'b1;
        ff_cyc = -1; done_cyc = -1; ready_cyc = -1;
        obs_j = 4'hx; obs_k = 4'hx; obs_err = 1'bx;
        @(posedge clk1);
        for (int cyc = 1; cyc <= 20 && ready_cyc < 0; cyc++) begin
            @(negedge clk1);
            tgt_valid = 1'b0;
            clr_err   = 1'b0;
            if (ff_en) begin ff_cyc = cyc; obs_j = j_out; obs_k = k_out; end
            if (done) begin
                done_cyc = cyc;
                obs_err  = err;
                if (clr_at_done) clr_err = 1'b1;
            end
            if (tgt_ready) ready_cyc = cyc;
        end
        clr_err      = 1'b0;
        obs_err_bits = err_bits;
        obs_err_cnt  = err_cnt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        rst = 1'b0;
        checks++;
        if ({tgt_ready, busy, ff_en, done, err} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got rdy/busy/en/done/err=%b want 10000",
                     {tgt_ready, busy, ff_en, done, err});
        end
        checks++;
        if ({j_out, k_out, err_bits, err_cnt} !== 20'd0) begin
            failures++;
            $display("FAIL reset_data: got j=%b k=%b eb=%b cnt=%0d want all 0",
                     j_out, k_out, err_bits, err_cnt);
        end
    endtask

    task automatic test_single();
        load_bank(4'b0000);
        do_op(4'b1010, 4'b1111, 1'b0);
        checks++;
        if (obs_j !== 4'b1010 || obs_k !== 4'b0000) begin
            failures++;
            $display("FAIL single_jk: got j=%b k=%b want j=1010 k=0000", obs_j, obs_k);
        end
        checks++;
        if (ff_cyc != 1 || done_cyc != 4 || ready_cyc != 5) begin
            failures++;
            $display("FAIL single_latency: got en=%0d done=%0d rdy=%0d want 1 4 5",
                     ff_cyc, done_cyc, ready_cyc);
        end
        checks++;
        if (obs_err !== 1'b0 || bank_q !== 4'b1010) begin
            failures++;
            $display("FAIL single_result: got err=%b bank=%b want err=0 bank=1010",
                     obs_err, bank_q);
        end
    endtask

    task automatic test_mixed();
        load_bank(4'b1100);
        do_op(4'b0110, 4'b1011, 1'b0);
        checks++;
        if (obs_j !== 4'b0010 || obs_k !== 4'b1000) begin
            failures++;
            $display("FAIL mixed_jk: got j=%b k=%b want j=0010 k=1000", obs_j, obs_k);
        end
        checks++;
        if (bank_q !== 4'b0110 || obs_err !== 1'b0 || obs_err_bits !== 4'b0000) begin
            failures++;
            $display("FAIL mixed_result: got bank=%b err=%b eb=%b want 0110 0 0000",
                     bank_q, obs_err, obs_err_bits);
        end
    endtask

    task automatic test_fault_saturate();
        stuck = 4'b0001;
        load_bank(4'b0000);
        do_op(4'b0001, 4'b1111, 1'b0);
        checks++;
        if (obs_err !== 1'b1 || obs_err_bits !== 4'b0001 || obs_err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL fault_first: got err=%b eb=%b cnt=%0d want 1 0001 1",
                     obs_err, obs_err_bits, obs_err_cnt);
        end
        for (int i = 2; i <= 300; i++) begin
            do_op(4'b0001, 4'b1111, 1'b0);
            if (i == 254 || i == 255 || i == 300) begin
                checks++;
                if (obs_err_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
                    failures++;
                    $display("FAIL fault_count_%0d: got cnt=%0d want %0d", i, obs_err_cnt,
                             (i > 255) ? 255 : i);
                end
            end
        end
        stuck = 4'b0000;
    endtask

    task automatic test_no_care();
        do_op(4'b1111, 4'b0000, 1'b0);
        checks++;
        if (ff_cyc != 1 || obs_j !== 4'b0000 || obs_k !== 4'b0000) begin
            failures++;
            $display("FAIL nocare_strobe: got en=%0d j=%b k=%b want 1 0000 0000",
                     ff_cyc, obs_j, obs_k);
        end
        checks++;
        if (obs_err !== 1'b0 || obs_err_bits !== 4'b0000 || obs_err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL nocare_check: got err=%b eb=%b cnt=%0d want 0 0000 255",
                     obs_err, obs_err_bits, obs_err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int dones = 0;
        tgt_data  = 4'b0101;
        tgt_care  = 4'b0000;
        tgt_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (tgt_valid && tgt_ready) accepts++;
            @(posedge clk1);
            @(negedge clk1);
            if (done) dones++;
        end
        tgt_valid = 1'b0;
        repeat (6) @(negedge clk1);
        checks++;
        if (accepts != 3 || dones != 3) begin
            failures++;
            $display("FAIL b2b_handshake: got accepts=%0d dones=%0d want 3 3", accepts, dones);
        end
    endtask

    task automatic test_clr_at_check();
        stuck = 4'b0001;
        load_bank(4'b0000);
        do_op(4'b0001, 4'b1111, 1'b1);
        stuck = 4'b0000;
        checks++;
        if (obs_err !== 1'b1 || obs_err_bits !== 4'b0000 || obs_err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clr_at_check: got err=%b eb=%b cnt=%0d want 1 0000 0",
                     obs_err, obs_err_bits, obs_err_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        int dones = 0;
        load_bank(4'b0000);
        tgt_data  = 4'b1111;
        tgt_care  = 4'b1111;
        tgt_valid = 1'b1;
        @(posedge clk1);
        @(negedge clk1);
        tgt_valid = 1'b0;
        @(negedge clk1);
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || tgt_ready !== 1'b1 || j_out !== 4'b0000 || k_out !== 4'b0000) begin
            failures++;
            $display("FAIL rst_wait_idle: got busy=%b rdy=%b j=%b k=%b want 0 1 0000 0000",
                     busy, tgt_ready, j_out, k_out);
        end
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            @(negedge clk1);
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL rst_wait_nodone: got dones=%0d want 0", dones);
        end
        do_op(4'b0101, 4'b1111, 1'b0);
        checks++;
        if (obs_j !== 4'b0000 || obs_k !== 4'b1010 || done_cyc != 4 || obs_err !== 1'b0
            || bank_q !== 4'b0101) begin
            failures++;
            $display("FAIL rst_wait_next: got j=%b k=%b done=%0d err=%b bank=%b want 0000 1010 4 0 0101",
                     obs_j, obs_k, done_cyc, obs_err, bank_q);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mixed();
        test_fault_saturate();
        test_no_care();
        test_back_to_back();
        test_clr_at_check();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
